// File: rtl/booth_controller.sv
// Booth multiplier sequencer: operand handshake, load/shift/add-sub control,
// iteration counter control, result handshake, and a watchdog that aborts a
// multiplication whose comparator flag never arrives.
module booth_controller #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned CNT_WIDTH = 5,
    parameter int unsigned TIMEOUT   = 20
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       src_valid_i,
    output logic       src_ready_o,
    output logic       dst_valid_o,
    input  logic       dst_ready_i,
    input  logic       comp_i,
    input  logic [1:0] q_bits_i,
    output logic       cnt_clr_o,
    output logic       cnt_en_o,
    output logic       load_en_o,
    output logic       shift_en_o,
    output logic [1:0] alu_op_o,
    output logic       busy_o,
    output logic       err_o
);

    localparam int unsigned WdWidth = CNT_WIDTH + 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StCalc = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [WdWidth-1:0] WdLast = WdWidth'(TIMEOUT - 1);
    localparam logic [WdWidth-1:0] WdMax  = {WdWidth{1'b1}};

    // A normal run must finish before the watchdog fires, and the watchdog
    // must be able to count up to its abort point.
    if (TIMEOUT <= WIDTH) begin : g_bad_timeout
        $error("booth_controller: TIMEOUT must exceed WIDTH");
    end
    if (TIMEOUT - 1 > 2 ** WdWidth - 1) begin : g_bad_wd_width
        $error("booth_controller: TIMEOUT does not fit the watchdog");
    end

    logic [1:0]         state_q, state_d;
    logic [WdWidth-1:0] wd_q, wd_d;
    logic               err_q, err_d;

    // Next-state, watchdog and error-flag logic.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                // src_ready is high in this state, so valid alone completes the handshake.
                if (src_valid_i) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                wd_d    = '0;
                state_d = StCalc;
            end
            StCalc: begin
                // Saturate so a stuck state can never wrap back below the abort point.
                wd_d = (wd_q == WdMax) ? wd_q : wd_q + 1'b1;
                if (comp_i) begin
                    state_d = StDone;
                    err_d   = 1'b0;
                end else if (wd_q == WdLast) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end
            end
            StDone: begin
                if (dst_ready_i) begin
                    state_d = StIdle;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                err_d   = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    // Moore control decode; alu_op additionally looks at the Booth bit pair.
    always_comb begin
        src_ready_o = 1'b0;
        dst_valid_o = 1'b0;
        cnt_clr_o   = 1'b0;
        cnt_en_o    = 1'b0;
        load_en_o   = 1'b0;
        shift_en_o  = 1'b0;
        alu_op_o    = 2'b00;
        busy_o      = 1'b1;
        case (state_q)
            StIdle: begin
                src_ready_o = 1'b1;
                busy_o      = 1'b0;
            end
            StLoad: begin
                load_en_o = 1'b1;
                cnt_clr_o = 1'b1;
            end
            StCalc: begin
                shift_en_o = 1'b1;
                cnt_en_o   = 1'b1;
                case (q_bits_i)
                    2'b10:   alu_op_o = 2'b10;
                    2'b01:   alu_op_o = 2'b01;
                    default: alu_op_o = 2'b00;
                endcase
            end
            StDone: begin
                dst_valid_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    assign err_o = err_q;

endmodule
